// File: rtl/case_1_mul_arb_pkg.sv
// Shared types and default widths for the multiplier-sharing arbiter.
// Slot states track each requester's single outstanding operation.
package case_1_mul_arb_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE     = 2'd0,
    SLOT_INFLIGHT = 2'd1,
    SLOT_DONE     = 2'd2
  } slot_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DIN0_WIDTH = 10;
  localparam int DEF_DIN1_WIDTH = 6;
  localparam int DEF_DOUT_WIDTH = 11;
  localparam int DEF_NUM_STAGE  = 2;

endpackage

// File: rtl/case_1_mul_pipe.sv
// Signed multiplier with NUM_STAGE register stages; valid and tag ride along.
// The product is formed at full width and truncated to OUT_W low bits.
module case_1_mul_pipe #(
  parameter int A_W       = 10,
  parameter int B_W       = 6,
  parameter int OUT_W     = 11,
  parameter int TAG_W     = 2,
  parameter int NUM_STAGE = 2
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [A_W-1:0]   in_din0,
  input  logic [B_W-1:0]   in_din1,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [OUT_W-1:0] out_dout
);
  localparam int P_W = A_W + B_W;

  logic [P_W-1:0]   ext_a;
  logic [P_W-1:0]   ext_b;
  logic [OUT_W-1:0] prod;

  // Sign-extended unsigned multiply gives the correct low P_W bits of the signed product.
  assign ext_a = {{B_W{in_din0[A_W-1]}}, in_din0};
  assign ext_b = {{A_W{in_din1[B_W-1]}}, in_din1};
  assign prod  = OUT_W'(ext_a * ext_b);

  if (NUM_STAGE == 0) begin : g_comb
    assign out_valid = in_valid;
    assign out_tag   = in_tag;
    assign out_dout  = prod;
  end else begin : g_reg
    logic             vld_q  [NUM_STAGE];
    logic [TAG_W-1:0] tag_q  [NUM_STAGE];
    logic [OUT_W-1:0] dout_q [NUM_STAGE];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
        for (int s = 0; s < NUM_STAGE; s++) begin
          vld_q[s] <= 1'b0;
          tag_q[s] <= '0;
        end
      end else begin
        vld_q[0] <= in_valid;
        tag_q[0] <= in_tag;
        for (int s = 1; s < NUM_STAGE; s++) begin
          vld_q[s] <= vld_q[s-1];
          tag_q[s] <= tag_q[s-1];
        end
      end
    end

    always_ff @(posedge ap_clk) begin
      dout_q[0] <= prod;
      for (int s = 1; s < NUM_STAGE; s++) dout_q[s] <= dout_q[s-1];
    end

    assign out_valid = vld_q[NUM_STAGE-1];
    assign out_tag   = tag_q[NUM_STAGE-1];
    assign out_dout  = dout_q[NUM_STAGE-1];
  end

endmodule

// File: rtl/case_1_mul_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier among NUM_REQ requesters.
//   state         | meaning
//   SLOT_IDLE     | no operation outstanding; eligible when req_valid is high
//   SLOT_INFLIGHT | operation issued, result still in the pipeline
//   SLOT_DONE     | result held in the slot register, rsp_valid high
module case_1_mul_arbiter
  import case_1_mul_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int din0_WIDTH = DEF_DIN0_WIDTH,
  parameter int din1_WIDTH = DEF_DIN1_WIDTH,
  parameter int dout_WIDTH = DEF_DOUT_WIDTH,
  parameter int NUM_STAGE  = DEF_NUM_STAGE
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*din0_WIDTH-1:0] req_din0,
  input  logic [NUM_REQ*din1_WIDTH-1:0] req_din1,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ*dout_WIDTH-1:0] rsp_dout,
  output logic                          busy
);
  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  slot_t                 slot_q [NUM_REQ];
  slot_t                 slot_d [NUM_REQ];
  logic [dout_WIDTH-1:0] res_q  [NUM_REQ];
  logic [TAG_W-1:0]      rr_ptr;
  logic [NUM_REQ-1:0]    eligible;
  logic                  grant_vld;
  logic [TAG_W-1:0]      grant_idx;
  logic [TAG_W-1:0]      cand;
  logic [din0_WIDTH-1:0] sel_din0;
  logic [din1_WIDTH-1:0] sel_din1;

  logic                  iss_valid;
  logic [TAG_W-1:0]      iss_tag;
  logic [din0_WIDTH-1:0] iss_din0;
  logic [din1_WIDTH-1:0] iss_din1;
  logic                  pipe_valid;
  logic [TAG_W-1:0]      pipe_tag;
  logic [dout_WIDTH-1:0] pipe_dout;
  logic                  cpl_ok;

  // Grants are suppressed while reset is asserted so req_ready reads 0 in reset.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_valid[i] && (slot_q[i] == SLOT_IDLE) && !ap_rst;
  end

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = TAG_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_din0  = '0;
    sel_din1  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && grant_idx == TAG_W'(i)) begin
        req_ready[i] = 1'b1;
        sel_din0     = req_din0[i*din0_WIDTH +: din0_WIDTH];
        sel_din1     = req_din1[i*din1_WIDTH +: din1_WIDTH];
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr    <= '0;
      iss_valid <= 1'b0;
    end else begin
      iss_valid <= grant_vld;
      if (grant_vld)
        rr_ptr <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (grant_vld) begin
      iss_tag  <= grant_idx;
      iss_din0 <= sel_din0;
      iss_din1 <= sel_din1;
    end
  end

  case_1_mul_pipe #(
    .A_W      (din0_WIDTH),
    .B_W      (din1_WIDTH),
    .OUT_W    (dout_WIDTH),
    .TAG_W    (TAG_W),
    .NUM_STAGE(NUM_STAGE)
  ) u_pipe (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .in_valid (iss_valid),
    .in_tag   (iss_tag),
    .in_din0  (iss_din0),
    .in_din1  (iss_din1),
    .out_valid(pipe_valid),
    .out_tag  (pipe_tag),
    .out_dout (pipe_dout)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i])
        SLOT_IDLE:     if (req_ready[i]) slot_d[i] = SLOT_INFLIGHT;
        SLOT_INFLIGHT: if (pipe_valid && pipe_tag == TAG_W'(i)) slot_d[i] = SLOT_DONE;
        SLOT_DONE:     if (rsp_ready[i]) slot_d[i] = SLOT_IDLE;
        default:       slot_d[i] = SLOT_IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= SLOT_IDLE;
        res_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= slot_d[i];
        if (pipe_valid && pipe_tag == TAG_W'(i)) res_q[i] <= pipe_dout;
      end
    end
  end

  // A completing tag must always land on a slot that is waiting for it.
  always_comb begin
    cpl_ok = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pipe_tag == TAG_W'(i) && slot_q[i] == SLOT_INFLIGHT) cpl_ok = 1'b1;
  end

  a_cpl_inflight: assert property (@(posedge ap_clk) disable iff (ap_rst) pipe_valid |-> cpl_ok);

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i]                        = (slot_q[i] == SLOT_DONE);
      rsp_dout[i*dout_WIDTH +: dout_WIDTH] = res_q[i];
      if (slot_q[i] != SLOT_IDLE) busy = 1'b1;
    end
  end

endmodule

// File: tb/tb_case_1_mul_arbiter.sv
// Directed bench for case_1_mul_arbiter: default build (NUM_STAGE=2) plus a NUM_STAGE=0 build.
// Inputs change 2 time units after each rising edge; outputs are sampled 1 unit later.
module tb_case_1_mul_arbiter;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [39:0] req_din0;
  logic [23:0] req_din1;
  logic [43:0] rsp_dout;
  logic        busy;

  logic [3:0]  req_valid_z, req_ready_z, rsp_valid_z, rsp_ready_z;
  logic [39:0] req_din0_z;
  logic [23:0] req_din1_z;
  logic [43:0] rsp_dout_z;
  logic        busy_z;

  int vectors     = 0;
  int miscompares = 0;
  logic proto_en  = 1'b0;

  always #5 ap_clk = ~ap_clk;

  case_1_mul_arbiter dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dout(rsp_dout), .busy(busy)
  );

  case_1_mul_arbiter #(.NUM_STAGE(0)) dut_z (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid_z), .req_ready(req_ready_z),
    .req_din0(req_din0_z), .req_din1(req_din1_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
    .rsp_dout(rsp_dout_z), .busy(busy_z)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #2;
  endtask

  task automatic set_ops(input int idx, input logic [9:0] a, input logic [5:0] b);
    req_din0[idx*10 +: 10] = a;
    req_din1[idx*6 +: 6]   = b;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 4'hF;
    repeat (8) tick();
    rsp_ready = '0;
  endtask

  // One isolated operation on requester idx; response held for 'hold' cycles before consumption.
  task automatic do_op(input int idx, input logic [9:0] a, input logic [5:0] b,
                       input logic [10:0] exp, input int hold);
    set_ops(idx, a, b);
    req_valid = 4'(1 << idx);
    #1;
    chk("op_ready", 64'(req_ready), 64'(1 << idx));
    tick();
    req_valid = '0;
    chk("op_busy", 64'(busy), 64'd1);
    chk("op_lat0", 64'(rsp_valid), 64'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("op_lat", 64'(rsp_valid), 64'd0);
    end
    tick();
    chk("op_valid", 64'(rsp_valid), 64'(1 << idx));
    chk("op_dout", 64'(rsp_dout[idx*11 +: 11]), 64'(exp));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("op_hold_valid", 64'(rsp_valid), 64'(1 << idx));
      chk("op_hold_dout", 64'(rsp_dout[idx*11 +: 11]), 64'(exp));
    end
    rsp_ready = 4'(1 << idx);
    tick();
    rsp_ready = '0;
    chk("op_consumed", 64'(rsp_valid), 64'd0);
    chk("op_dout_kept", 64'(rsp_dout[idx*11 +: 11]), 64'(exp));
    chk("op_idle", 64'(busy), 64'd0);
  endtask

  // A requester stalled at one edge must keep valid and operands at the next.
  logic [3:0]  stall_q = '0;
  logic [39:0] d0_q;
  logic [23:0] d1_q;
  always @(posedge ap_clk) begin
    if (proto_en && !ap_rst) begin
      for (int i = 0; i < 4; i++) begin
        if (stall_q[i] && (!req_valid[i] || req_din0[i*10 +: 10] != d0_q[i*10 +: 10] ||
                           req_din1[i*6 +: 6] != d1_q[i*6 +: 6])) begin
          miscompares++;
          $error("FAIL proto_stable req=%0d observed valid=%0b expected=1", i, req_valid[i]);
        end
      end
    end
    stall_q <= req_valid & ~req_ready;
    d0_q    <= req_din0;
    d1_q    <= req_din1;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int          q[$];
    int          cnt[4];
    logic        flag;
    logic [63:0] obs;

    ap_rst      = 1'b1;
    req_valid   = '0; req_din0   = '0; req_din1   = '0; rsp_ready   = '0;
    req_valid_z = '0; req_din0_z = '0; req_din1_z = '0; rsp_ready_z = '0;

    repeat (3) tick();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_dout", 64'(rsp_dout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    req_valid = 4'hF;
    #1;
    chk("rst_ready_gated", 64'(req_ready), 64'd0);
    req_valid = '0;
    tick();
    ap_rst = 1'b0;
    tick();

    // 100 * -3 = -300 -> 11'h6D4, held four cycles under backpressure
    do_op(0, 10'h064, 6'h3D, 11'h6D4, 4);

    // NUM_STAGE=0 build: -7 * 5 = -35 -> 11'h7DD one cycle after acceptance
    req_din0_z[20 +: 10] = 10'h3F9;
    req_din1_z[12 +: 6]  = 6'h05;
    req_valid_z = 4'b0100;
    #1;
    chk("z_ready", 64'(req_ready_z), 64'b0100);
    tick();
    req_valid_z = '0;
    chk("z_lat0", 64'(rsp_valid_z), 64'd0);
    tick();
    chk("z_valid", 64'(rsp_valid_z), 64'b0100);
    chk("z_dout", 64'(rsp_dout_z[22 +: 11]), 64'h7DD);
    rsp_ready_z = 4'b0100;
    tick();
    rsp_ready_z = '0;
    chk("z_consumed", 64'(rsp_valid_z), 64'd0);

    // Wrap cases: 511*31 = 15841 -> 11'h5E1; -512*-32 = 16384 -> 0
    do_op(1, 10'h1FF, 6'h1F, 11'h5E1, 0);
    do_op(1, 10'h200, 6'h20, 11'h000, 0);

    // Round robin with all requesters busy; rr_ptr is 2 after the grants above
    for (int i = 0; i < 4; i++) set_ops(i, 10'(i + 1), 6'h02);
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    proto_en  = 1'b1;
    flag      = 1'b0;
    #1;
    for (int s = 0; s < 20; s++) begin
      if (req_ready != 0) q.push_back($clog2(req_ready));
      if (!$onehot0(req_ready)) flag = 1'b1;
      tick();
      #1;
    end
    chk("rr_onehot", 64'(flag), 64'd0);
    chk("rr_enough", 64'(q.size() >= 12), 64'd1);
    for (int k = 0; k < 12; k++) begin
      obs = (k < q.size()) ? 64'(q[k]) : 64'd99;
      chk("rr_order", obs, 64'((2 + k) % 4));
    end
    proto_en = 1'b0;
    drain();

    // Backpressure on requester 1
    rsp_ready = 4'b1101;
    req_valid = 4'hF;
    proto_en  = 1'b1;
    flag      = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    #1;
    for (int s = 0; s < 14; s++) begin
      for (int i = 0; i < 4; i++) if (req_ready[i]) cnt[i]++;
      if (!busy && s > 0) flag = 1'b1;
      tick();
      #1;
    end
    chk("bp_one_grant", 64'(cnt[1]), 64'd1);
    chk("bp_others_served", 64'(cnt[0] >= 2 && cnt[2] >= 2 && cnt[3] >= 2), 64'd1);
    chk("bp_busy", 64'(flag), 64'd0);
    chk("bp_rsp_held", 64'(rsp_valid[1]), 64'd1);
    rsp_ready = 4'hF;
    #1;
    chk("bp_no_ready_at_hs", 64'(req_ready[1]), 64'd0);
    flag = 1'b0;
    for (int s = 0; s < 8 && !flag; s++) begin
      tick();
      #1;
      if (req_ready[1]) flag = 1'b1;
    end
    chk("bp_regrant", 64'(flag), 64'd1);
    proto_en = 1'b0;
    drain();

    // Reset with three operations in the pipeline
    for (int i = 0; i < 3; i++) set_ops(i, 10'h005, 6'h03);
    rsp_ready = 4'hF;
    req_valid = 4'b0111;
    repeat (3) tick();
    chk("mid_busy", 64'(busy), 64'd1);
    #1;
    ap_rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_dout", 64'(rsp_dout), 64'd0);
    tick();
    tick();
    req_valid = '0;
    ap_rst    = 1'b0;
    flag      = 1'b0;
    for (int s = 0; s < 8; s++) begin
      tick();
      if (rsp_valid != 0 || busy) flag = 1'b1;
    end
    chk("post_rst_quiet", 64'(flag), 64'd0);
    req_valid = 4'hF;
    #1;
    chk("post_rst_grant0", 64'(req_ready), 64'b0001);
    tick();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
